// File: rtl/traffic_lamp_ctrl.sv
// Lamp, countdown and pedestrian-walk controller fed by the traffic-light sequencer.
// Watches the count/state sequence and falls back to flashing yellow on any illegal step.
module traffic_lamp_ctrl #(
  parameter int unsigned GREEN_LEN  = 25,
  parameter int unsigned YELLOW_LEN = 3,
  parameter int unsigned RED_LEN    = 14,
  parameter int unsigned WALK_CLEAR = 3,
  parameter int unsigned BLINK_DIV  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] count,
  input  logic [1:0] state,
  input  logic       ped_btn,
  output logic       lamp_g,
  output logic       lamp_y,
  output logic       lamp_r,
  output logic       walk,
  output logic       ped_wait,
  output logic [3:0] remain_tens,
  output logic [3:0] remain_ones,
  output logic       fault
);

  localparam int unsigned Period = GREEN_LEN + YELLOW_LEN + RED_LEN;
  localparam logic [5:0] YellowStart = 6'(GREEN_LEN);
  localparam logic [5:0] RedStart    = 6'(GREEN_LEN + YELLOW_LEN);
  localparam logic [5:0] PeriodLen   = 6'(Period);
  localparam logic [5:0] LastCount   = 6'(Period - 1);
  localparam logic [5:0] WalkLast    = 6'(Period - 1 - WALK_CLEAR);
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  localparam logic [1:0] PhS0     = 2'd0;
  localparam logic [1:0] PhGreen  = 2'd1;
  localparam logic [1:0] PhYellow = 2'd2;
  localparam logic [1:0] PhRed    = 2'd3;

  typedef enum logic [1:0] {StIdle, StRun, StFault} fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [5:0]        count_q, prev_count_q;
  logic [1:0]        state_q, prev_state_q;
  logic              btn_q, btn_qq, press_q;
  logic              walk_grant_q, walk_grant_d;
  logic              ped_wait_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;

  logic [1:0] phase_exp;
  logic [5:0] next_count;
  logic       seq_err;
  logic       red_entry;
  logic [5:0] remain;
  logic [3:0] tens_d, ones_d;
  logic       lamp_g_d, lamp_y_d, lamp_r_d, walk_d;

  // Sequence legality of the current registered sample.
  always_comb begin
    if (count_q < YellowStart) begin
      phase_exp = PhGreen;
    end else if (count_q < RedStart) begin
      phase_exp = PhYellow;
    end else begin
      phase_exp = PhRed;
    end
    next_count = (prev_count_q == LastCount) ? 6'd0 : prev_count_q + 6'd1;
    seq_err    = (count_q > LastCount) || (state_q != phase_exp) || (count_q != next_count);
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      StIdle: if (state_q == PhGreen && count_q == 6'd0) fsm_d = StRun;
      StRun: begin
        if (state_q == PhS0) begin
          fsm_d = StIdle;
        end else if (seq_err) begin
          fsm_d = StFault;
        end
      end
      StFault: fsm_d = StFault;
      default: fsm_d = StIdle;
    endcase
  end

  // Blink phase restarts "on" at every fault entry.
  always_comb begin
    blink_cnt_d = '0;
    blink_on_d  = 1'b0;
    if (fsm_d == StFault) begin
      if (fsm_q != StFault) begin
        blink_on_d = 1'b1;
      end else if (blink_cnt_q == BlinkLast) begin
        blink_on_d = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_on_d  = blink_on_q;
      end
    end
  end

  always_comb begin
    remain = 6'd0;
    if (fsm_d == StRun) begin
      case (state_q)
        PhGreen:  remain = YellowStart - count_q;
        PhYellow: remain = RedStart - count_q;
        PhRed:    remain = PeriodLen - count_q;
        default:  remain = 6'd0;
      endcase
    end
    if (remain >= 6'd60) begin
      tens_d = 4'd6;
    end else if (remain >= 6'd50) begin
      tens_d = 4'd5;
    end else if (remain >= 6'd40) begin
      tens_d = 4'd4;
    end else if (remain >= 6'd30) begin
      tens_d = 4'd3;
    end else if (remain >= 6'd20) begin
      tens_d = 4'd2;
    end else if (remain >= 6'd10) begin
      tens_d = 4'd1;
    end else begin
      tens_d = 4'd0;
    end
    // Low nibble minus 10*tens, modulo 16, is exactly the ones digit.
    ones_d = remain[3:0] - ({tens_d[0], 3'b000} + {tens_d[2:0], 1'b0});
  end

  assign red_entry = (state_q == PhRed) && (prev_state_q != PhRed);

  // A pending request is granted before a coincident new press is considered.
  always_comb begin
    ped_wait_d   = ped_wait;
    walk_grant_d = walk_grant_q;
    if (fsm_d == StFault) begin
      ped_wait_d   = 1'b0;
      walk_grant_d = 1'b0;
    end else begin
      if (state_q != PhRed || fsm_d != StRun) walk_grant_d = 1'b0;
      if (fsm_d == StRun && red_entry && ped_wait) begin
        walk_grant_d = 1'b1;
        ped_wait_d   = 1'b0;
      end else if (press_q && !walk_grant_q) begin
        ped_wait_d = 1'b1;
      end
    end
    walk_d = walk_grant_d && (fsm_d == StRun) && (count_q <= WalkLast);
  end

  always_comb begin
    lamp_g_d = 1'b0;
    lamp_y_d = 1'b0;
    lamp_r_d = 1'b0;
    case (fsm_d)
      StRun: begin
        lamp_g_d = (state_q == PhGreen);
        lamp_y_d = (state_q == PhYellow);
        lamp_r_d = (state_q == PhRed);
      end
      StFault: lamp_y_d = blink_on_d;
      default: lamp_r_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q        <= StIdle;
      count_q      <= 6'd0;
      prev_count_q <= 6'd0;
      state_q      <= PhS0;
      prev_state_q <= PhS0;
      btn_q        <= 1'b0;
      btn_qq       <= 1'b0;
      press_q      <= 1'b0;
      walk_grant_q <= 1'b0;
      blink_cnt_q  <= '0;
      blink_on_q   <= 1'b0;
      lamp_g       <= 1'b0;
      lamp_y       <= 1'b0;
      lamp_r       <= 1'b1;
      walk         <= 1'b0;
      ped_wait     <= 1'b0;
      remain_tens  <= 4'd0;
      remain_ones  <= 4'd0;
      fault        <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      count_q      <= count;
      prev_count_q <= count_q;
      state_q      <= state;
      prev_state_q <= state_q;
      btn_q        <= ped_btn;
      btn_qq       <= btn_q;
      press_q      <= btn_q & ~btn_qq;
      walk_grant_q <= walk_grant_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      lamp_g       <= lamp_g_d;
      lamp_y       <= lamp_y_d;
      lamp_r       <= lamp_r_d;
      walk         <= walk_d;
      ped_wait     <= ped_wait_d;
      remain_tens  <= tens_d;
      remain_ones  <= ones_d;
      fault        <= (fsm_d == StFault);
    end
  end

endmodule

// File: tb/tb_traffic_lamp_ctrl.sv
// Directed bench for traffic_lamp_ctrl: normal periods, pedestrian handshake,
// sequence faults with blink, and reset overrides.
module tb_traffic_lamp_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] count;
  logic [1:0] state;
  logic       ped_btn;
  logic       lamp_g, lamp_y, lamp_r, walk, ped_wait, fault;
  logic [3:0] remain_tens, remain_ones;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        chk;
    logic [11:0] val;
  } exp_t;
  exp_t exp_q[$];

  logic [13:0] outs;
  assign outs = {lamp_g, lamp_y, lamp_r, walk, ped_wait, fault, remain_tens, remain_ones};

  traffic_lamp_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .count       (count),
    .state       (state),
    .ped_btn     (ped_btn),
    .lamp_g      (lamp_g),
    .lamp_y      (lamp_y),
    .lamp_r      (lamp_r),
    .walk        (walk),
    .ped_wait    (ped_wait),
    .remain_tens (remain_tens),
    .remain_ones (remain_ones),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  function automatic logic [1:0] phase_of(input int c);
    if (c < 25) return 2'd1;
    if (c < 28) return 2'd2;
    return 2'd3;
  endfunction

  // {g, y, r, fault, tens, ones} for a legal RUN sample at count c.
  function automatic logic [11:0] exp_run(input int c);
    int rem;
    logic [2:0] lamps;
    if (c < 25) begin
      rem = 25 - c; lamps = 3'b100;
    end else if (c < 28) begin
      rem = 28 - c; lamps = 3'b010;
    end else begin
      rem = 42 - c; lamps = 3'b001;
    end
    return {lamps, 1'b0, 4'(rem / 10), 4'(rem % 10)};
  endfunction

  // mode: 0 no lamp check, 1 legal RUN sample, 2 IDLE expected.
  task automatic tick(input int c, input logic [1:0] s, input logic b, input int mode);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      if (e.chk) check("lamps_remain", 16'({lamp_g, lamp_y, lamp_r, fault, remain_tens,
                                             remain_ones}), 16'(e.val));
    end
    count   = 6'(c);
    state   = s;
    ped_btn = b;
    e.chk = (mode != 0);
    e.val = (mode == 1) ? exp_run(c) : 12'b0010_0000_0000;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; count = 6'd0; state = 2'd0; ped_btn = 1'b0;
    @(negedge clk);
    check("reset_outputs", 16'(outs), 16'h0800);
    reset = 1'b1;
    exp_q.delete();
  endtask

  // Walk is observed for driven counts 30..40 (samples 28..38, two clocks back).
  task automatic run_period(input int press_a, input int press_b, input bit walk_exp,
                            input int pw_lo, input int pw_hi, input int last);
    for (int c = 0; c <= last; c++) begin
      tick(c, phase_of(c), (c == press_a) || (c == press_b), 1);
      check("walk", 16'(walk), 16'(walk_exp && c >= 30 && c <= 40));
      check("ped_wait", 16'(ped_wait), 16'(c >= pw_lo && c <= pw_hi));
    end
  endtask

  initial begin
    reset = 1'b0; count = 6'd0; state = 2'd0; ped_btn = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) tick(0, 2'd0, 1'b0, 2);

    run_period(-1, -1, 1'b0, 99, -1, 41);  // plain period
    run_period(5, 30, 1'b1, 8, 29, 41);    // green press granted; press during walk ignored
    run_period(-1, 30, 1'b0, 33, 41, 41);  // red press with no grant is latched
    run_period(-1, -1, 1'b1, 0, 29, 34);   // served at next red entry

    // Reset mid-red with walk active.
    @(negedge clk);
    reset = 1'b0; count = 6'd35; state = 2'd3;
    @(negedge clk);
    check("reset_mid_red", 16'(outs), 16'h0800);
    reset = 1'b1; count = 6'd36;
    exp_q.delete();
    exp_q.push_back('{chk: 1'b1, val: 12'b0010_0000_0000});
    for (int c = 37; c <= 41; c++) begin
      tick(c, 2'd3, 1'b0, 2);
      check("idle_walk", 16'(walk), 16'h0);
    end
    run_period(-1, -1, 1'b0, 99, -1, 41);  // RUN resumes at green 0

    // Fault by count jump 10 -> 12, with a request pending beforehand.
    run_period(2, -1, 1'b0, 5, 10, 10);
    tick(12, 2'd1, 1'b0, 0);
    tick(13, 2'd1, 1'b0, 0);
    check("fault_pre_jump", 16'(fault), 16'h0);
    for (int j = 0; j < 24; j++) begin
      tick(14 + j, phase_of(14 + j), j == 3, 0);
      check("fault_jump", 16'(fault), 16'h1);
      check("blink_y", 16'(lamp_y), 16'(((j / 8) % 2) == 0));
      check("fault_other", 16'({lamp_g, lamp_r, walk, ped_wait, remain_tens, remain_ones}),
            16'h0);
    end
    do_reset();
    for (int i = 0; i < 3; i++) tick(0, 2'd0, 1'b0, 2);

    // Fault by state YELLOW at count 10.
    run_period(-1, -1, 1'b0, 99, -1, 9);
    tick(10, 2'd2, 1'b0, 0);
    tick(11, 2'd1, 1'b0, 0);
    check("fault_pre_state", 16'(fault), 16'h0);
    for (int j = 0; j < 10; j++) begin
      tick(12 + j, 2'd1, 1'b0, 0);
      check("fault_state", 16'(fault), 16'h1);
      check("blink_y2", 16'(lamp_y), 16'(j < 8));
      check("fault_g", 16'({lamp_g, lamp_r}), 16'h0);
    end
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
